// File: rtl/dmem_write_monitor_pkg.sv
// rtl/dmem_write_monitor_pkg.sv - shared types and defaults for the data-memory write monitor
package dmem_monitor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    typedef enum logic [1:0] {NONE, BAD_DATA, BAD_ADDR, TIMEOUT} fail_cause_t;

    localparam logic [31:0] DEFAULT_DONE_ADDR  = 32'd100;
    localparam logic [31:0] DEFAULT_DONE_DATA  = 32'd7;
    localparam logic [31:0] DEFAULT_ADDR_LO    = 32'd0;
    localparam logic [31:0] DEFAULT_ADDR_HI    = 32'd252;
    localparam int          DEFAULT_MAX_CYCLES = 1000;
    localparam int          DEFAULT_CNT_W      = 16;

    // Offset compare keeps the range check a single unsigned test even when lo is 0.
    function automatic logic addr_illegal(input logic [31:0] adr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        return ((adr - lo) > (hi - lo)) || (adr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_write_monitor_if.sv
// rtl/dmem_write_monitor_if.sv - core data-memory write port seen by the monitor
interface dmem_write_monitor_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    modport master (output MemWrite, output DataAdr, output WriteData);
    modport slave  (input  MemWrite, input  DataAdr, input  WriteData);

endinterface

// File: rtl/dmem_write_monitor_sat_counter.sv
// rtl/dmem_write_monitor_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/dmem_write_monitor.sv
// rtl/dmem_write_monitor.sv - end-of-program PASS/FAIL checker on the core's store port
module dmem_write_monitor
    import dmem_monitor_pkg::*;
#(
    parameter logic [31:0] DONE_ADDR  = DEFAULT_DONE_ADDR,
    parameter logic [31:0] DONE_DATA  = DEFAULT_DONE_DATA,
    parameter logic [31:0] ADDR_LO    = DEFAULT_ADDR_LO,
    parameter logic [31:0] ADDR_HI    = DEFAULT_ADDR_HI,
    parameter int          MAX_CYCLES = DEFAULT_MAX_CYCLES,
    parameter int          CNT_W      = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    dmem_write_monitor_if.slave  bus,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_cause,
    output logic [CNT_W-1:0]     write_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [31:0]          last_adr,
    output logic [31:0]          last_data
);

    localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES - 1);

    state_t      state, state_n;
    fail_cause_t cause, cause_n;
    logic        in_run;
    logic        store;
    logic        run_entry;
    logic        cyc_en;
    logic        at_done_adr;
    logic        data_ok;
    logic        bad_adr;

    assign in_run      = (state == RUN);
    assign store       = in_run && bus.MemWrite;
    assign run_entry   = (state == IDLE) && start;
    // The cycle counter parks on the timeout cycle so a timed-out run reports MAX_CYCLES-1.
    assign cyc_en      = in_run && (cycle_count != CYC_LIMIT);
    assign at_done_adr = (bus.DataAdr == DONE_ADDR);
    assign data_ok     = (bus.WriteData == DONE_DATA);
    assign bad_adr     = addr_illegal(bus.DataAdr, ADDR_LO, ADDR_HI);

    always_comb begin
        state_n = state;
        cause_n = cause;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (store && at_done_adr && data_ok) begin
                    state_n = PASS;
                end else if (store && at_done_adr) begin
                    state_n = FAIL;
                    cause_n = BAD_DATA;
                end else if (store && bad_adr) begin
                    state_n = FAIL;
                    cause_n = BAD_ADDR;
                end else if (cycle_count == CYC_LIMIT) begin
                    state_n = FAIL;
                    cause_n = TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cause <= NONE;
        end else begin
            state <= state_n;
            cause <= cause_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_adr  <= '0;
            last_data <= '0;
        end else if (store) begin
            last_adr  <= bus.DataAdr;
            last_data <= bus.WriteData;
        end
    end

    sat_counter #(.W(CNT_W)) u_write_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (run_entry),
        .en    (store),
        .q     (write_count)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (run_entry),
        .en    (cyc_en),
        .q     (cycle_count)
    );

    assign pass       = (state == PASS);
    assign fail       = (state == FAIL);
    assign done       = pass | fail;
    assign fail_cause = cause;

endmodule

// File: tb/tb_dmem_write_monitor.sv
// tb/tb_dmem_write_monitor.sv - self-checking bench for dmem_write_monitor
module tb_dmem_write_monitor;

    localparam int MAXC = 20;

    logic        clk   = 1'b1;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done, pass, fail;
    logic [1:0]  fail_cause;
    logic [15:0] write_count, cycle_count;
    logic [31:0] last_adr, last_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        we_a  [64];
    logic [31:0] adr_a [64];
    logic [31:0] dat_a [64];

    dmem_write_monitor_if bus ();

    dmem_write_monitor #(
        .MAX_CYCLES (MAXC),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .fail_cause  (fail_cause),
        .write_count (write_count),
        .cycle_count (cycle_count),
        .last_adr    (last_adr),
        .last_data   (last_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) assert (!$isunknown(bus.MemWrite))
            else $error("FAIL memwrite_known: MemWrite is X/Z");
    end

    task automatic clear_seq();
        for (int i = 0; i < 64; i++) begin
            we_a[i]  = 1'b0;
            adr_a[i] = 32'd0;
            dat_a[i] = 32'd0;
        end
    endtask

    task automatic set_store(input int i, input logic [31:0] a, input logic [31:0] d);
        we_a[i]  = 1'b1;
        adr_a[i] = a;
        dat_a[i] = d;
    endtask

    // Reset at one falling edge, release with start raised at the next.
    task automatic begin_run();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
    endtask

    // Drives n RUN cycles from the tables and checks final outputs against the model.
    task automatic run_scenario(input string name, input int n);
        logic        running, e_pass, e_fail;
        logic [1:0]  e_cause;
        int          e_wc, e_cc;
        logic [31:0] e_la, e_ld;
        running = 1'b1; e_pass = 1'b0; e_fail = 1'b0; e_cause = 2'd0;
        e_wc = 0; e_cc = 0; e_la = 32'd0; e_ld = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (running) begin
                if (we_a[i]) begin
                    e_wc++;
                    e_la = adr_a[i];
                    e_ld = dat_a[i];
                    if (adr_a[i] == 32'd100 && dat_a[i] == 32'd7) begin
                        e_pass = 1'b1; running = 1'b0;
                    end else if (adr_a[i] == 32'd100) begin
                        e_fail = 1'b1; e_cause = 2'd1; running = 1'b0;
                    end else if (adr_a[i] > 32'd252 || (adr_a[i] % 4) != 0) begin
                        e_fail = 1'b1; e_cause = 2'd2; running = 1'b0;
                    end
                end
                if (running && i == MAXC - 1) begin
                    e_fail = 1'b1; e_cause = 2'd3; running = 1'b0;
                end
                e_cc = (i + 1 < MAXC - 1) ? i + 1 : MAXC - 1;
            end
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start         = 1'b0;
            bus.MemWrite  = we_a[i];
            bus.DataAdr   = adr_a[i];
            bus.WriteData = dat_a[i];
        end
        @(negedge clk);
        start = 1'b0;
        bus.MemWrite = 1'b0;
        n_cmp++; if (done !== (e_pass | e_fail)) begin n_fail++; $display("FAIL %s done: got %b want %b", name, done, e_pass | e_fail); end
        n_cmp++; if (pass !== e_pass) begin n_fail++; $display("FAIL %s pass: got %b want %b", name, pass, e_pass); end
        n_cmp++; if (fail !== e_fail) begin n_fail++; $display("FAIL %s fail: got %b want %b", name, fail, e_fail); end
        n_cmp++; if (fail_cause !== e_cause) begin n_fail++; $display("FAIL %s fail_cause: got %0d want %0d", name, fail_cause, e_cause); end
        n_cmp++; if (write_count !== 16'(e_wc)) begin n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, write_count, e_wc); end
        n_cmp++; if (cycle_count !== 16'(e_cc)) begin n_fail++; $display("FAIL %s cycle_count: got %0d want %0d", name, cycle_count, e_cc); end
        n_cmp++; if (last_adr !== e_la) begin n_fail++; $display("FAIL %s last_adr: got %0d want %0d", name, last_adr, e_la); end
        n_cmp++; if (last_data !== e_ld) begin n_fail++; $display("FAIL %s last_data: got %0d want %0d", name, last_data, e_ld); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({done, pass, fail, fail_cause} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {done, pass, fail, fail_cause}); end
        n_cmp++; if ({write_count, cycle_count} !== 32'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", write_count, cycle_count); end
        n_cmp++; if ({last_adr, last_data} !== 64'd0) begin n_fail++; $display("FAIL reset_last: got %0d/%0d want 0/0", last_adr, last_data); end
        #10 reset = 1'b0;
        #3  start = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_pass();
        clear_seq();
        set_store(0, 32'd96, 32'd3);
        set_store(1, 32'd100, 32'd7);
        run_scenario("t1_pass", 2);
    endtask

    task automatic test_bad_data();
        begin_run();
        clear_seq();
        set_store(0, 32'd100, 32'd5);
        set_store(1, 32'd100, 32'd7);
        run_scenario("t2_bad_data", 3);
    endtask

    task automatic test_bad_addr();
        begin_run();
        clear_seq();
        set_store(0, 32'd256, 32'd1);
        run_scenario("t3_out_of_range", 2);
        begin_run();
        clear_seq();
        set_store(0, 32'd6, 32'd1);
        run_scenario("t3_misaligned", 2);
    endtask

    task automatic test_timeout();
        begin_run();
        clear_seq();
        run_scenario("t4_timeout", MAXC + 3);
        begin_run();
        clear_seq();
        set_store(MAXC - 1, 32'd100, 32'd7);
        run_scenario("t4_pass_on_limit", MAXC + 3);
    endtask

    task automatic test_idle_stores();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.MemWrite  = 1'b1;
            bus.DataAdr   = 32'd100;
            bus.WriteData = 32'd7;
            @(negedge clk);
        end
        bus.MemWrite = 1'b0;
        n_cmp++; if (write_count !== 16'd0) begin n_fail++; $display("FAIL t5_idle_write_count: got %0d want 0", write_count); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL t5_idle_done: got %b want 0", done); end
        n_cmp++; if (last_adr !== 32'd0) begin n_fail++; $display("FAIL t5_idle_last_adr: got %0d want 0", last_adr); end
        start = 1'b1;
        clear_seq();
        set_store(0, 32'd96, 32'd1);
        set_store(1, 32'd100, 32'd7);
        run_scenario("t5_after_start", 2);
    endtask

    task automatic test_reset_mid_run();
        begin_run();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start         = 1'b0;
            bus.MemWrite  = 1'b1;
            bus.DataAdr   = 32'(8 + 4 * i);
            bus.WriteData = 32'(i + 1);
        end
        @(negedge clk);
        bus.MemWrite = 1'b0;
        n_cmp++; if (write_count !== 16'd3) begin n_fail++; $display("FAIL t6_pre_reset_writes: got %0d want 3", write_count); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({done, pass, fail, fail_cause} !== 5'b0) begin n_fail++; $display("FAIL t6_async_flags: got %b want 00000", {done, pass, fail, fail_cause}); end
        n_cmp++; if ({write_count, cycle_count} !== 32'd0) begin n_fail++; $display("FAIL t6_async_counts: got %0d/%0d want 0/0", write_count, cycle_count); end
        n_cmp++; if ({last_adr, last_data} !== 64'd0) begin n_fail++; $display("FAIL t6_async_last: got %0d/%0d want 0/0", last_adr, last_data); end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        clear_seq();
        set_store(0, 32'd100, 32'd7);
        run_scenario("t6_restart", 1);
    endtask

    task automatic test_random();
        int r, n;
        for (int k = 0; k < 25; k++) begin
            begin_run();
            clear_seq();
            n = $urandom_range(3, 26);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 99);
                we_a[i] = 1'($urandom_range(0, 1));
                if (r < 80) begin
                    adr_a[i] = 32'($urandom_range(0, 63) * 4);
                    if (adr_a[i] == 32'd100) adr_a[i] = 32'd96;
                    dat_a[i] = $urandom;
                end else if (r < 85) begin
                    adr_a[i] = 32'd100; dat_a[i] = 32'd7;
                end else if (r < 90) begin
                    adr_a[i] = 32'd100; dat_a[i] = 32'($urandom_range(8, 200));
                end else if (r < 95) begin
                    adr_a[i] = 32'($urandom_range(64, 1000) * 4); dat_a[i] = $urandom;
                end else begin
                    adr_a[i] = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)); dat_a[i] = $urandom;
                end
            end
            run_scenario($sformatf("random_%0d", k), n);
        end
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'd0;
        bus.WriteData = 32'd0;
        test_reset();
        test_pass();
        test_bad_data();
        test_bad_addr();
        test_timeout();
        test_idle_stores();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
